// File: rtl/cla2_seq_adder.sv
// cla2_seq_adder: a WIDTH-bit adder/subtractor built from one 2-bit
// carry-lookahead slice. The slice is reused once per clock, lowest bits first.
// The carry is held in a register from one slice to the next.
// Results appear on sum/co/ovf only once the last slice has been processed.

// fa2_cla: 2-bit carry-lookahead adder slice (generate/propagate form).
module fa2_cla (
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic       ci,
    output logic [1:0] sum,
    output logic       co
);

    logic [1:0] g;
    logic [1:0] p;
    logic       c1;

    assign g   = a & b;
    assign p   = a ^ b;
    assign c1  = g[0] | (p[0] & ci);
    assign co  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign sum = p ^ {c1, ci};

endmodule

module cla2_seq_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);

    localparam int SLICES = WIDTH / 2;
    localparam int KW     = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [KW-1:0] LAST_K = KW'(SLICES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Operands are captured at launch. Subtraction is stored as A + ~B + 1,
    // so the B register already holds the effective operand.
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] shadow;

    logic [1:0]       slice_a;
    logic [1:0]       slice_b;
    logic [1:0]       slice_sum;
    logic             slice_co;
    logic [WIDTH-1:0] sum_next;
    logic             launch;
    logic             last_slice;
    logic             ovf_next;

    // An operation may start from IDLE, or directly from DONE for back-to-back use.
    // A start request that arrives during RUN is ignored.
    assign launch     = start && ((state == S_IDLE) || (state == S_DONE));
    assign last_slice = (state == S_RUN) && (k == LAST_K);

    assign slice_a = a_reg[{k, 1'b0} +: 2];
    assign slice_b = b_reg[{k, 1'b0} +: 2];

    fa2_cla u_slice (
        .a   (slice_a),
        .b   (slice_b),
        .ci  (carry),
        .sum (slice_sum),
        .co  (slice_co)
    );

    // Merge the current slice result into the shadow to form the complete word.
    always_comb begin
        sum_next = shadow;
        sum_next[{k, 1'b0} +: 2] = slice_sum;
    end

    // Overflow: both operands have the same sign, but the result sign differs.
    assign ovf_next = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                      (sum_next[WIDTH-1] != a_reg[WIDTH-1]);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and status outputs. DONE lasts exactly one cycle.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (k == LAST_K) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    state_next = S_RUN;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: capture operands at launch, then process one slice per clock in RUN.
    // Visible results are updated only on the last slice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg  <= '0;
            b_reg  <= '0;
            carry  <= 1'b0;
            k      <= '0;
            shadow <= '0;
            sum    <= '0;
            co     <= 1'b0;
            ovf    <= 1'b0;
        end else if (launch) begin
            a_reg  <= a;
            b_reg  <= op_sub ? ~b : b;
            carry  <= op_sub ? 1'b1 : ci;
            k      <= '0;
            shadow <= '0;
        end else if (state == S_RUN) begin
            shadow <= sum_next;
            carry  <= slice_co;
            if (last_slice) begin
                k   <= '0;
                sum <= sum_next;
                co  <= slice_co;
                ovf <= ovf_next;
            end else begin
                k <= k + KW'(1);
            end
        end
    end

endmodule

// File: doc/cla2_seq_adder.md
CLA2_SEQ_ADDER -- requirements
Module: cla2_seq_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width; SHALL be an even value >= 4.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request; sampled high while busy=0 launches an operation.
REQ-005 op_sub  input  1  0 = A+B+ci, 1 = A-B (two's complement); sampled with start.
REQ-006 a  input  WIDTH  operand A; sampled with start.
REQ-007 b  input  WIDTH  operand B; sampled with start.
REQ-008 ci  input  1  carry-in for add; ignored when op_sub=1; sampled with start.
REQ-009 busy  output  1  high while slices are being processed (state RUN).
REQ-010 done  output  1  one-cycle pulse; result outputs valid.
REQ-011 sum  output  WIDTH  result, held from done until the next accepted start completes.
REQ-012 co  output  1  carry-out of MSB slice (add: carry; sub: 1 = no borrow).
REQ-013 ovf  output  1  signed overflow of the completed operation.

Function
REQ-014 Arithmetic SHALL be done by one 2-bit carry-lookahead slice (the team's FA2_CLA: A[1:0], B[1:0], CI, SUM[1:0], CO) reused once per cycle; no wider adder SHALL be instantiated.
REQ-015 States: IDLE, RUN, DONE; encoding free.
REQ-016 IDLE: start=1 -> latch a, b (b inverted if op_sub), op_sub, initial carry (ci for add, 1 for sub), clear slice index; go RUN.
REQ-017 RUN: each edge feeds slice index k (bits 2k+1:2k) with the carry register, writes the 2 result bits into the sum shadow, stores slice CO into the carry register, increments k.
REQ-018 RUN -> DONE on the edge that processes slice WIDTH/2-1; on that edge sum, co, ovf SHALL be updated.
REQ-019 DONE: done=1 for exactly that cycle; start=1 -> behaves as IDLE start (back-to-back launch, next state RUN); else -> IDLE.
REQ-020 Latency: start sampled at edge E0 -> done high in the cycle after edge E(WIDTH/2) (WIDTH=8: edges E1-E4 compute, done visible at E5 sample).
REQ-021 busy=1 exactly in RUN; start while busy=1 SHALL be ignored with no effect on the operation in flight.
REQ-022 Changes on a, b, ci, op_sub after the start edge SHALL NOT affect the result.
REQ-023 ovf = (a[MSB] == b_eff[MSB]) and (sum[MSB] != a[MSB]), b_eff being the possibly-inverted B.
REQ-024 Wrap-around: results SHALL be modulo 2^WIDTH, carry reported only via co.
REQ-025 sum, co, ovf SHALL change only on the final RUN edge; intermediate slice results SHALL NOT be visible on sum.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, busy=0, done=0, sum=0, co=0, ovf=0, slice index and carry register to 0.
REQ-027 Reset during RUN or DONE SHALL abort the operation; no done pulse SHALL follow release.
REQ-028 First start SHALL be accepted on the first rising edge with rst_n high.

Verification
REQ-029 WIDTH=8, a=0x5A, b=0x33, ci=1, add -> done at E5, sum=0x8E, co=0, ovf=1; busy high E1-E4 only.
REQ-030 a=0xFF, b=0x01, ci=0, add -> sum=0x00, co=1, ovf=0 (full-width carry ripple through all slices).
REQ-031 op_sub, a=0x10, b=0x20 -> sum=0xF0, co=0, ovf=0; then a=0x80, b=0x01 -> sum=0x7F, co=1, ovf=1.
REQ-032 start pulsed again at E2 with different operands, a/b changed mid-run -> first result unaffected; second start ignored; done once.
REQ-033 start held high continuously -> back-to-back ops, done every 5 cycles, each sum correct for operands at its launch edge.
REQ-034 rst_n dropped at E3 of an operation, released, idle 3 cycles -> all outputs 0, no done; next start completes normally; exhaustive 2-bit-per-slice sweep of a, b, ci against a reference model passes.
